// File: rtl/rr_arbiter_4_pkg.sv
// Shared constants, state encoding and the round-robin search helper
// for the four-requester arbiter.
package rr_arbiter_4_pkg;

    localparam int NUM_REQ          = 4;
    localparam int DEFAULT_HOLD_MAX = 8;
    localparam int DEFAULT_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Returns {found, winner}: first set bit of req scanning ptr, ptr+1, ... mod 4.
    // The scan runs from the farthest offset down so the nearest one wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Requester-side bundle of the arbiter: request/enable in, grant/status out.
interface rr_arbiter_4_if;
    import rr_arbiter_4_pkg::*;

    // req is level-sensitive; grant is one-hot and nonzero exactly while busy,
    // and an owner keeps it until it drops req, times out or en falls.
    logic         en;
    logic [3:0]   req;
    logic [3:0]   grant;
    logic [1:0]   grant_idx;
    logic         busy;
    state_t       dbg_state;

    modport master (output en, req, input grant, grant_idx, busy, dbg_state);
    modport slave  (input en, req, output grant, grant_idx, busy, dbg_state);

endinterface

// File: rtl/rr_arbiter_4_decoder_2x4.sv
// 2-to-4 one-hot decoder with enable; {a,b} selects the asserted output bit.
module decoder_2x4 (
    input  logic       a,
    input  logic       b,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) y[{a, b}] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with time-limited registered grants
// and a one-cycle dead gap between owners.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int HOLD_MAX = DEFAULT_HOLD_MAX,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_4_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_grant_idx;
    logic             w_found;
    logic [1:0]       w_winner;
    logic             w_start;
    logic             w_release;
    logic             w_busy;
    logic [3:0]       w_grant;

    assign {w_found, w_winner} = rr_pick(bus.req, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_start     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (bus.en && w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_hold_nxt  = '0;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Release, timeout and disable collapse into one termination.
                if (!bus.req[r_grant_idx] || (r_hold_cnt == HOLD_LAST) || !bus.en) begin
                    w_state_nxt = ST_GAP;
                    w_hold_nxt  = '0;
                    w_release   = 1'b1;
                end else begin
                    w_hold_nxt  = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_idx <= 2'd0;
            r_ptr       <= 2'd0;
        end else begin
            if (w_start)   r_grant_idx <= w_winner;
            if (w_release) r_ptr       <= r_grant_idx + 2'd1;
        end
    end

    assign w_busy = (r_state == ST_GRANT);

    decoder_2x4 u_dec (
        .a  (r_grant_idx[1]),
        .b  (r_grant_idx[0]),
        .en (w_busy),
        .y  (w_grant)
    );

    assign bus.grant     = w_grant;
    assign bus.grant_idx = r_grant_idx;
    assign bus.busy      = w_busy;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter. It shares one downstream resource between four requesters and produces the one-hot select that gates that resource. Grants are registered and time-limited, with a one-cycle dead gap between owners. The one-hot select is built by decoding the registered 2-bit owner index with the team's 2x4 decoder, using the grant-valid signal as the decoder enable.

## Interface
- HOLD_MAX, default 8: maximum consecutive cycles any one grant may stay asserted; legal range 1..2**CNT_W.
- CNT_W, default 4: width of the hold counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  global enable; low blocks new grants and ends the current one.
- req  input  4  request vector; bit i is requester i, level-sensitive.
- grant  output  4  one-hot grant; all zero when no owner.
- grant_idx  output  2  index of the current or last owner.
- busy  output  1  high exactly when the arbiter is in GRANT.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner holds the resource.
  - GAP: one-cycle dead time after a release.
- Registers:
  - state
  - ptr[1:0]: round-robin start point.
  - grant_idx[1:0]
  - hold_cnt[CNT_W-1:0]
- Search: scan req in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins.
- IDLE or GAP, at a clock edge:
  - en=1 and req≠0: state→GRANT, grant_idx←winner, hold_cnt←0.
  - Otherwise: state→IDLE. grant_idx holds its value.
- GRANT, at a clock edge, the grant terminates if req[grant_idx]=0, or hold_cnt=HOLD_MAX-1, or en=0.
  - On termination: state→GAP, ptr←grant_idx+1 (2-bit wrap, so 3→0), hold_cnt←0.
  - Otherwise: hold_cnt←hold_cnt+1.
- GAP always lasts exactly one cycle, during which grant=0. This applies even if the same requester is still requesting.
- grant = decode(grant_idx) when state=GRANT, else 4'b0000.
- busy = (state==GRANT).
- Requests from non-owners never preempt the owner. Only a release, timeout or en=0 ends a grant.
- A requester that drops req and re-raises it during GAP competes normally from the new ptr.
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE, ptr=0, grant_idx=0, hold_cnt=0.
  - grant=0000, busy=0.

## Timing
- Latency from req rising in IDLE to grant: 1 cycle. req is sampled at edge k and grant is asserted after edge k.
- Maximum grant length: HOLD_MAX cycles. With HOLD_MAX=1, every grant is exactly 1 cycle.
- Release latency: req[owner] low before edge k → grant low after edge k.
- Handover under continuous demand follows a period of (grant cycles + 1). Worst-case wait for any requester is 3×(HOLD_MAX+1) cycles.
- Simultaneous release and timeout at the same edge: a single termination; ptr advances once.
- en falling during GRANT: grant drops at the next edge. en low in IDLE/GAP: no grant is issued regardless of req.
- rst_n deassertion is applied to asynchronously reset flops only. The first possible grant comes at the first edge after release.

## Structure
- Shared constants include file:
  - State encodings: IDLE=2'b00, GRANT=2'b01, GAP=2'b10.
  - Requester count: 4.
  - Default HOLD_MAX.
- Sub-module decoder_2x4, instanced once:
  - a=grant_idx[1], b=grant_idx[0].
  - en=(state==GRANT).
  - Output drives grant.
- Two always blocks:
  - FSM plus counters.
  - Registered grant_idx/ptr update.
- Round-robin search is a combinational dataflow function of req and ptr.

## Test plan
- Reset: assert rst_n=0 mid-run with req=1111 → grant=0000, busy=0, grant_idx=0 immediately without a clock edge. After release with req=1111 → grant=0001 one cycle later.
- Single request: req=0100 in IDLE → grant=0100, grant_idx=2 after 1 edge. Drop req → grant=0000 after the next edge. The next grant search starts at ptr=3.
- Fairness, HOLD_MAX=4, req=1111 held → sequence is 0001 for 4 cycles, 0000 for 1, then 0010, 0100 and 1000 each for 4 cycles separated by 1-cycle gaps, then 0001. Repeat 3 rounds.
- Pointer priority: after owner 0 releases (ptr=1), req=0101 → grant=0100 (idx 2), not 0001.
- Enable:
  - en=0 with req=0010 → no grant for 10 cycles.
  - en=1 → grant=0010 one cycle later.
  - en=0 mid-grant → grant=0000 after the next edge; state is GAP, then IDLE.
- HOLD_MAX=1 with req=1001 → alternating 0001, 0000, 1000, 0000, 0001, …; busy mirrors grant≠0.
